// File: rtl/iob_ram_mport_arb_pkg.sv
// Shared parameters and response-pipeline types for the multi-port RAM arbiter.
// Build macro IOB_RAM_MPORT_ARB_RD_REG_EN selects registered read data (2-cycle latency).
package iob_ram_mport_arb_pkg;

`ifdef IOB_RAM_MPORT_ARB_RD_REG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

  // Port-id field sized for the largest supported configuration (8 ports).
  localparam int unsigned RSP_ID_W = 3;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic                is_read;
  } rsp_entry_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_ram_mport_arb_rr_arbiter.sv
// Parametrised round-robin arbiter: registered last-winner pointer, one-hot and
// encoded combinational grant; the search starts one past the last winner.
module iob_rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_c_o,
  output logic [ID_W-1:0] gnt_id_c_o,
  output logic            gnt_vld_c_o
);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;

  // Rotating priority search; first requester after last_q wins.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    logic            found;
    gnt_c_o     = '0;
    gnt_id_c_o  = '0;
    gnt_vld_c_o = 1'b0;
    last_d      = last_q;
    idx         = 0;
    cand        = '0;
    found       = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = ID_W'(idx);
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        gnt_id_c_o    = cand;
      end
    end
    gnt_vld_c_o = found;
    if (found) begin
      last_d = gnt_id_c_o;
    end
  end

  // Pointer resets to the last port so port 0 has first priority.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_q <= ID_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/iob_ram_mport_arb.sv
// Multi-port round-robin front end for a single-port byte-enabled SRAM.
// Build macro IOB_RAM_MPORT_ARB_RD_REG_EN adds a read-data register (latency 2).
module iob_ram_mport_arb
  import iob_ram_mport_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_n_i,
  input  logic [N_PORTS-1:0]            valid_i,
  input  logic [N_PORTS*ADDR_W-1:0]     addr_i,
  input  logic [N_PORTS*DATA_W-1:0]     wdata_i,
  input  logic [N_PORTS*DATA_W/8-1:0]   wstrb_i,
  output logic [N_PORTS-1:0]            ready_o,
  output logic [N_PORTS-1:0]            rvalid_o,
  output logic [N_PORTS*DATA_W-1:0]     rdata_o,
  output logic                          mem_en_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W/8-1:0]           mem_we_o,
  output logic [DATA_W-1:0]             mem_d_o,
  input  logic [DATA_W-1:0]             mem_d_i
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ARB_ID_W = id_width(N_PORTS);

  logic [N_PORTS-1:0]  gnt_c;
  logic [ARB_ID_W-1:0] gnt_id_c;
  logic                gnt_vld_c;
  logic                sel_rd_c;
  logic [DATA_W-1:0]   rd_bus_c;

  rsp_entry_t pipe_q [RD_LAT];
  rsp_entry_t pipe_d [RD_LAT];

  iob_rr_arbiter #(
    .N    (N_PORTS),
    .ID_W (ARB_ID_W)
  ) u_arb (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .en_i        (cke_i),
    .req_i       (valid_i),
    .gnt_c_o     (gnt_c),
    .gnt_id_c_o  (gnt_id_c),
    .gnt_vld_c_o (gnt_vld_c)
  );

  assign ready_o  = gnt_c;
  assign mem_en_o = gnt_vld_c;

  // Payload mux: the granted port's slices drive the SRAM, zeros when idle.
  always_comb begin
    mem_addr_o = '0;
    mem_we_o   = '0;
    mem_d_o    = '0;
    sel_rd_c   = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (gnt_c[p]) begin
        mem_addr_o = addr_i[p*ADDR_W +: ADDR_W];
        mem_we_o   = wstrb_i[p*STRB_W +: STRB_W];
        mem_d_o    = wdata_i[p*DATA_W +: DATA_W];
        sel_rd_c   = ~|wstrb_i[p*STRB_W +: STRB_W];
      end
    end
  end

  // Response pipeline advances only on enabled cycles, matching the SRAM hold.
  always_comb begin
    pipe_d = pipe_q;
    if (cke_i) begin
      pipe_d[0] = '{id: RSP_ID_W'(gnt_id_c), is_read: gnt_vld_c && sel_rd_c};
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      rvalid_o[p] = pipe_q[RD_LAT-1].is_read && (pipe_q[RD_LAT-1].id == RSP_ID_W'(p));
    end
  end

`ifdef IOB_RAM_MPORT_ARB_RD_REG_EN
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (cke_i) begin
      rdata_d = mem_d_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rd_bus_c = rdata_q;
`else
  assign rd_bus_c = mem_d_i;
`endif

  assign rdata_o = {N_PORTS{rd_bus_c}};

  // Grant invariants.
  a_ready_onehot : assert property (@(posedge clk_i) disable iff (!arst_n_i)
    $onehot0(ready_o));
  a_ready_valid  : assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (ready_o & ~valid_i) == '0);
  a_stall_idle   : assert property (@(posedge clk_i) disable iff (!arst_n_i)
    !cke_i |-> !mem_en_o);

endmodule
